// File: rtl/usb_pkg.sv
// Shared constants and types for the full-speed USB transmit PHY.
package usb_pkg;

  // SYNC pattern, sent LSB-first: KJKJKJKK on the line.
  localparam logic [7:0] USB_SYNC_BYTE = 8'h80;

  // Consecutive '1' data bits after which a '0' is stuffed.
  localparam int unsigned STUFF_LIMIT = 6;

  // Line state as {dp, dm}.
  typedef logic [1:0] line_t;
  localparam line_t LS_J   = 2'b10;
  localparam line_t LS_K   = 2'b01;
  localparam line_t LS_SE0 = 2'b00;

  typedef enum logic [2:0] {
    StIdle,
    StSync,
    StData,
    StAbort,
    StEopSe0,
    StEopJ
  } tx_state_e;

endpackage

// File: rtl/usb_nrzi_stuff.sv
// Bit-level encoder: NRZI level register plus the bit-stuffing ones counter.
module usb_nrzi_stuff
  import usb_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clear,     // restart from J with an empty ones counter
  input  logic bit_stb,   // one bit is being put on the line this clk
  input  logic bit_in,
  input  logic stuff_en,
  output logic stuff_req, // the next bit must be a stuffed '0'
  output logic level      // 1 = J, 0 = K
);

  logic       level_q, level_d;
  logic [2:0] ones_q, ones_d;

  // Next NRZI level and ones count; clear applies before the new bit.
  always_comb begin
    level_d = level_q;
    ones_d  = ones_q;
    if (clear) begin
      level_d = 1'b1;
      ones_d  = '0;
    end
    if (bit_stb) begin
      if (!bit_in) begin
        level_d = ~level_d;
      end
      ones_d = (bit_in && stuff_en) ? ones_d + 3'd1 : 3'd0;
    end
  end

  // Encoder state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= 1'b1;
      ones_q  <= '0;
    end else begin
      level_q <= level_d;
      ones_q  <= ones_d;
    end
  end

  assign stuff_req = (ones_q == 3'(STUFF_LIMIT));
  assign level     = level_q;

endmodule

// File: rtl/usb_phy_tx.sv
// Full-speed USB transmit serializer: SYNC, LSB-first payload, bit stuffing,
// NRZI and SE0-SE0-J EOP, with abort by stuff violation on cancel/underrun.
module usb_phy_tx
  import usb_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned ABORT_LEN = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_lp_sop,
  input  logic       tx_lp_eop,
  input  logic       tx_lp_valid,
  output logic       tx_lp_ready,
  input  logic [7:0] tx_lp_data,
  input  logic       tx_lp_cancle,
  output logic       dp_o,
  output logic       dm_o,
  output logic       tx_oe,
  output logic       tx_busy
);

  localparam int unsigned CntW = $clog2(CLK_DIV);
  localparam int unsigned AbW  = $clog2(ABORT_LEN + 1);
  localparam logic [CntW-1:0] CntMax   = CntW'(CLK_DIV - 1);
  localparam logic [AbW-1:0]  AbortMax = AbW'(ABORT_LEN);

  tx_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      sreg_q, sreg_d;
  logic [2:0]      bits_left_q, bits_left_d;
  logic            last_q, last_d;       // byte in sreg is the eop byte
  logic [7:0]      buf_q, buf_d;
  logic            buf_eop_q, buf_eop_d;
  logic            buf_full_q, buf_full_d;
  logic            cancel_q, cancel_d;
  logic [AbW-1:0]  abort_cnt_q, abort_cnt_d;
  logic            se0_cnt_q, se0_cnt_d;
  logic            busy_q, busy_d;

  logic  tick, accept;
  logic  enc_clear, enc_stb, enc_bit, enc_stuff_en;
  logic  stuff_req, level;
  line_t line;

  assign tick   = (state_q != StIdle) && (cnt_q == CntMax);
  // Once the eop byte is in the shift register nothing more may enter the buffer,
  // so the next packet's sop byte waits for IDLE.
  assign tx_lp_ready = !buf_full_q && !last_q &&
                       (state_q inside {StIdle, StSync, StData});
  assign accept = tx_lp_valid && tx_lp_ready;

  usb_nrzi_stuff u_enc (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (enc_clear),
    .bit_stb   (enc_stb),
    .bit_in    (enc_bit),
    .stuff_en  (enc_stuff_en),
    .stuff_req (stuff_req),
    .level     (level)
  );

  // Next-state, buffer handling and choice of the next line bit at each bit boundary.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sreg_d       = sreg_q;
    bits_left_d  = bits_left_q;
    last_d       = last_q;
    buf_d        = buf_q;
    buf_eop_d    = buf_eop_q;
    buf_full_d   = buf_full_q;
    cancel_d     = cancel_q;
    abort_cnt_d  = abort_cnt_q;
    se0_cnt_d    = se0_cnt_q;
    enc_clear    = 1'b0;
    enc_stb      = 1'b0;
    enc_bit      = 1'b0;
    enc_stuff_en = 1'b1;

    if (state_q == StIdle || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    // Non-sop bytes offered in IDLE are swallowed without line activity.
    if (accept && (state_q != StIdle || tx_lp_sop)) begin
      buf_d      = tx_lp_data;
      buf_eop_d  = tx_lp_eop;
      buf_full_d = 1'b1;
    end

    if (tx_lp_cancle && (state_q inside {StSync, StData})) begin
      cancel_d = 1'b1;
    end

    case (state_q)
      StIdle: begin
        cancel_d = 1'b0;
        if (accept && tx_lp_sop) begin
          state_d     = StSync;
          sreg_d      = USB_SYNC_BYTE >> 1;
          bits_left_d = 3'd7;
          last_d      = 1'b0;
          enc_clear   = 1'b1;
          enc_stb     = 1'b1;
          enc_bit     = USB_SYNC_BYTE[0];
        end
      end
      StSync, StData: begin
        if (tick) begin
          if (cancel_q) begin
            state_d      = StAbort;
            enc_stb      = 1'b1;
            enc_bit      = 1'b1;
            enc_stuff_en = 1'b0;
            abort_cnt_d  = AbW'(1);
            buf_full_d   = 1'b0;
            cancel_d     = 1'b0;
            last_d       = 1'b0;
          end else if (stuff_req) begin
            // Stuff bit takes priority, also after the final data bit.
            enc_stb = 1'b1;
            enc_bit = 1'b0;
          end else if (bits_left_q != 3'd0) begin
            enc_stb     = 1'b1;
            enc_bit     = sreg_q[0];
            sreg_d      = {1'b0, sreg_q[7:1]};
            bits_left_d = bits_left_q - 3'd1;
          end else if (last_q) begin
            state_d    = StEopSe0;
            se0_cnt_d  = 1'b0;
            last_d     = 1'b0;
            buf_full_d = 1'b0;
          end else if (buf_full_q) begin
            state_d     = StData;
            enc_stb     = 1'b1;
            enc_bit     = buf_q[0];
            sreg_d      = {1'b0, buf_q[7:1]};
            bits_left_d = 3'd7;
            last_d      = buf_eop_q;
            buf_full_d  = 1'b0;
          end else begin
            // Underrun: no byte ready at the boundary and no eop seen.
            state_d      = StAbort;
            enc_stb      = 1'b1;
            enc_bit      = 1'b1;
            enc_stuff_en = 1'b0;
            abort_cnt_d  = AbW'(1);
            buf_full_d   = 1'b0;
          end
        end
      end
      StAbort: begin
        if (tick) begin
          if (abort_cnt_q < AbortMax) begin
            enc_stb      = 1'b1;
            enc_bit      = 1'b1;
            enc_stuff_en = 1'b0;
            abort_cnt_d  = abort_cnt_q + AbW'(1);
          end else begin
            state_d   = StEopSe0;
            se0_cnt_d = 1'b0;
          end
        end
      end
      StEopSe0: begin
        if (tick) begin
          if (!se0_cnt_q) begin
            se0_cnt_d = 1'b1;
          end else begin
            state_d   = StEopJ;
            enc_clear = 1'b1;
          end
        end
      end
      StEopJ: begin
        if (tick) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      sreg_q      <= '0;
      bits_left_q <= '0;
      last_q      <= 1'b0;
      buf_q       <= '0;
      buf_eop_q   <= 1'b0;
      buf_full_q  <= 1'b0;
      cancel_q    <= 1'b0;
      abort_cnt_q <= '0;
      se0_cnt_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sreg_q      <= sreg_d;
      bits_left_q <= bits_left_d;
      last_q      <= last_d;
      buf_q       <= buf_d;
      buf_eop_q   <= buf_eop_d;
      buf_full_q  <= buf_full_d;
      cancel_q    <= cancel_d;
      abort_cnt_q <= abort_cnt_d;
      se0_cnt_q   <= se0_cnt_d;
      busy_q      <= busy_d;
    end
  end

  // Line drive: SE0 during the EOP SE0 phase, otherwise the NRZI level.
  always_comb begin
    line = level ? LS_J : LS_K;
    if (state_q == StEopSe0) begin
      line = LS_SE0;
    end
  end

  assign dp_o    = line[1];
  assign dm_o    = line[0];
  assign tx_oe   = busy_q;
  assign tx_busy = busy_q;

endmodule

// File: tb/tb_usb_phy_tx.sv
// Scoreboarded bench: stimulus queues expected packets, a line monitor decodes
// NRZI, removes stuff bits and compares each packet as it ends.
module tb_usb_phy_tx;

  localparam int CLK_DIV = 4;
  localparam int MaxSym  = 128;

  typedef struct {
    logic [31:0] bytes;  // byte i at [8*i +: 8]
    int nb;
    int left;
    int abrt;
    int trail;
    int stuffs;
    int total;
    int trunc;
  } exp_t;

  logic       clk, rst_n;
  logic       tx_lp_sop, tx_lp_eop, tx_lp_valid, tx_lp_ready, tx_lp_cancle;
  logic [7:0] tx_lp_data;
  logic       dp_o, dm_o, tx_oe, tx_busy;

  int   checks = 0;
  int   errors = 0;
  int   hs_cnt = 0;
  exp_t sb[$];
  logic m_active = 1'b0;

  usb_phy_tx #(.CLK_DIV(CLK_DIV), .ABORT_LEN(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tx_lp_sop    (tx_lp_sop),
    .tx_lp_eop    (tx_lp_eop),
    .tx_lp_valid  (tx_lp_valid),
    .tx_lp_ready  (tx_lp_ready),
    .tx_lp_data   (tx_lp_data),
    .tx_lp_cancle (tx_lp_cancle),
    .dp_o         (dp_o),
    .dm_o         (dm_o),
    .tx_oe        (tx_oe),
    .tx_busy      (tx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] bytes, input int nb, input int left,
                              input int abrt, input int trail, input int stuffs,
                              input int total, input int trunc);
    exp_t e;
    e.bytes = bytes; e.nb = nb; e.left = left; e.abrt = abrt; e.trail = trail;
    e.stuffs = stuffs; e.total = total; e.trunc = trunc;
    return e;
  endfunction

  // Handshakes seen: valid and ready at a negedge means acceptance at the next posedge.
  always @(negedge clk) begin
    if (tx_lp_valid && tx_lp_ready) hs_cnt++;
  end

  // ---------------- line monitor / scoreboard checker ----------------
  logic [1:0] m_sym [0:MaxSym-1];
  logic       m_raw [0:MaxSym-1];
  logic       m_dat [0:MaxSym-1];
  int         m_n, m_nraw, m_nse0, m_jafter, m_bad, m_nd, m_ones, m_stuffs, m_trail;
  int         m_viol, m_busy;
  logic [1:0] m_lvl;
  logic [7:0] m_byte;
  exp_t       m_e;

  always begin
    @(negedge clk);
    if (tx_oe === 1'b1) begin
      m_active = 1'b1;
      m_n = 1;
      m_sym[0] = {dp_o, dm_o};
      while (m_n < MaxSym) begin
        repeat (CLK_DIV) @(negedge clk);
        if (tx_oe !== 1'b1) break;
        m_sym[m_n] = {dp_o, dm_o};
        m_n++;
      end
      m_busy = int'(tx_busy);
      // NRZI decode up to the first SE0, then classify the EOP tail.
      m_lvl = 2'b10; m_nraw = 0; m_nse0 = 0; m_jafter = 0; m_bad = 0;
      for (int i = 0; i < m_n; i++) begin
        if (m_sym[i] == 2'b00) m_nse0++;
        else if (m_sym[i] == 2'b11) m_bad++;
        else if (m_nse0 > 0) begin
          if (m_sym[i] == 2'b10) m_jafter++;
          else m_bad++;
        end else begin
          m_raw[m_nraw] = (m_sym[i] == m_lvl);
          m_lvl = m_sym[i];
          m_nraw++;
        end
      end
      // De-stuff; the ones run starts inside SYNC.
      m_ones = 0; m_nd = 0; m_viol = 0; m_stuffs = 0;
      for (int i = 0; i < m_nraw && m_viol == 0; i++) begin
        if (m_ones == 6) begin
          if (m_raw[i]) m_viol = 1;
          else begin m_stuffs++; m_ones = 0; end
        end else begin
          if (i >= 8) begin m_dat[m_nd] = m_raw[i]; m_nd++; end
          m_ones = m_raw[i] ? m_ones + 1 : 0;
        end
      end
      if (m_viol != 0 && m_nd >= 6) m_nd -= 6;  // drop the abort ones before the violation
      m_trail = 0;
      for (int i = m_nraw - 1; i >= 0; i--) begin
        if (!m_raw[i]) break;
        m_trail++;
      end
      chk("sb_expected_pkt", (sb.size() > 0) ? 1 : 0, 1);
      if (sb.size() > 0) begin
        m_e = sb.pop_front();
        chk("busy_low_after_pkt", m_busy, 0);
        if (m_e.trunc != 0) begin
          chk("trunc_no_eop", m_nse0, 0);
        end else begin
          m_byte = '0;
          for (int i = 0; i < 8 && i < m_nraw; i++) m_byte[i] = m_raw[i];
          chk("sync", int'(m_byte), 8'h80);
          chk("total_bits", m_n, m_e.total);
          chk("se0_bits", m_nse0, 2);
          chk("eop_j_bits", m_jafter, 1);
          chk("illegal_syms", m_bad, 0);
          chk("abort_viol", m_viol, m_e.abrt);
          chk("trailing_ones", m_trail, m_e.trail);
          chk("stuff_bits", m_stuffs, m_e.stuffs);
          chk("n_bytes", m_nd / 8, m_e.nb);
          chk("left_bits", m_nd % 8, m_e.left);
          for (int b = 0; b < 4; b++) begin
            if (b < m_e.nb && b < m_nd / 8) begin
              for (int k = 0; k < 8; k++) m_byte[k] = m_dat[8 * b + k];
              chk($sformatf("byte%0d", b), int'(m_byte), int'(m_e.bytes[8 * b +: 8]));
            end
          end
        end
      end
      m_active = 1'b0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic send_byte(input logic [7:0] d, input logic sop, input logic eop,
                           input int gap, input int bound, output logic ok);
    repeat (gap) @(negedge clk);
    @(negedge clk);
    tx_lp_data = d; tx_lp_sop = sop; tx_lp_eop = eop; tx_lp_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (tx_lp_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (ok) @(posedge clk);
    #1;
    tx_lp_valid = 1'b0; tx_lp_sop = 1'b0; tx_lp_eop = 1'b0;
  endtask

  task automatic wait_idle();
    int i;
    i = 0;
    while ((sb.size() != 0 || m_active || tx_busy) && i < 2000) begin
      @(negedge clk);
      i++;
    end
    chk("idle_timeout", (i < 2000) ? 1 : 0, 1);
    repeat (4) @(negedge clk);
  endtask

  logic ok, ok4;
  int   hs0, oe_seen;

  initial begin
    rst_n = 1'b0; tx_lp_sop = 1'b0; tx_lp_eop = 1'b0; tx_lp_valid = 1'b0;
    tx_lp_data = '0; tx_lp_cancle = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_dp", int'(dp_o), 1);
    chk("rst_dm", int'(dm_o), 0);
    chk("rst_oe", int'(tx_oe), 0);
    chk("rst_busy", int'(tx_busy), 0);
    chk("rst_ready", int'(tx_lp_ready), 1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Non-sop byte in IDLE is dropped without line activity.
    send_byte(8'h5A, 1'b0, 1'b1, 0, 10, ok);
    chk("nosop_taken", int'(ok), 1);
    oe_seen = 0;
    repeat (20) begin @(negedge clk); if (tx_oe) oe_seen++; end
    chk("nosop_no_line", oe_seen, 0);

    // ACK handshake packet.
    sb.push_back(mk(32'h000000D2, 1, 0, 0, 2, 0, 19, 0));
    send_byte(8'hD2, 1'b1, 1'b1, 0, 10, ok);
    chk("ack_taken", int'(ok), 1);
    wait_idle();

    // Stuffing across byte boundaries, including a trailing stuff bit.
    sb.push_back(mk(32'h00FFFFC3, 3, 0, 0, 0, 3, 38, 0));
    send_byte(8'hC3, 1'b1, 1'b0, 0, 10, ok);
    send_byte(8'hFF, 1'b0, 1'b0, 0, 200, ok);
    send_byte(8'hFF, 1'b0, 1'b1, 0, 200, ok);
    wait_idle();

    // Valid gaps between bytes: no underrun, one handshake per byte.
    hs0 = hs_cnt;
    sb.push_back(mk(32'h563412C3, 4, 0, 0, 0, 0, 43, 0));
    send_byte(8'hC3, 1'b1, 1'b0, 0, 10, ok);
    send_byte(8'h12, 1'b0, 1'b0, 3, 200, ok);
    send_byte(8'h34, 1'b0, 1'b0, 3, 200, ok);
    send_byte(8'h56, 1'b0, 1'b1, 3, 200, ok);
    wait_idle();
    chk("bp_handshakes", hs_cnt - hs0, 4);

    // Cancel while byte 2 is on the line: 5 zero bits then 8 abort ones.
    sb.push_back(mk(32'h000000C3, 1, 5, 1, 8, 0, 32, 0));
    send_byte(8'hC3, 1'b1, 1'b0, 0, 10, ok);
    fork
      begin
        send_byte(8'h00, 1'b0, 1'b0, 0, 200, ok);
        send_byte(8'h00, 1'b0, 1'b0, 0, 200, ok);
        send_byte(8'h00, 1'b0, 1'b1, 0, 40, ok4);
      end
      begin
        repeat (81) @(negedge clk);
        tx_lp_cancle = 1'b1;
        @(negedge clk);
        tx_lp_cancle = 1'b0;
      end
    join
    chk("cancel_b4_not_taken", int'(ok4), 0);
    wait_idle();

    // Underrun right after the PID.
    sb.push_back(mk(32'h0000004B, 1, 0, 1, 8, 0, 27, 0));
    send_byte(8'h4B, 1'b1, 1'b0, 0, 10, ok);
    wait_idle();

    // Reset in the middle of DATA, then a clean packet.
    sb.push_back(mk(32'h0, 0, 0, 0, 0, 0, 0, 1));
    send_byte(8'hC3, 1'b1, 1'b0, 0, 10, ok);
    send_byte(8'h55, 1'b0, 1'b0, 0, 200, ok);
    repeat (41) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_dp", int'(dp_o), 1);
    chk("midrst_dm", int'(dm_o), 0);
    chk("midrst_oe", int'(tx_oe), 0);
    chk("midrst_busy", int'(tx_busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_idle();
    sb.push_back(mk(32'h000000D2, 1, 0, 0, 2, 0, 19, 0));
    send_byte(8'hD2, 1'b1, 1'b1, 0, 10, ok);
    chk("post_rst_taken", int'(ok), 1);
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
